bus_interface_unit: RTL and testbench
=====================================

// Module: bus_interface_unit
// PURPOSE
//  Pad-side bus sequencer between the 6502 core and the TinyTapeout pins.
//  Takes one 16-bit address/8-bit data request from the core, time-multiplexes
//  the address onto the 8 dedicated outputs (high byte, then low byte), then
//  drives or samples the bidirectional pins, with external wait states.
//  Returns read data plus a fetched-opcode register that feeds instruction decode.
// PARAMETERS
//  MAX_WAIT  15     max DATA-phase cycles waiting on ext_rdy before timeout (1..255)
//  IR_RESET  8'hEA  instruction-register value after reset (NOP)
// PORTS
//  clk        in   1   system clock; all state on posedge
//  rst_n      in   1   synchronous, active-low reset
//  req        in   1   core bus request; sampled only in IDLE
//  rw         in   1   1=read, 0=write; captured with req
//  addr       in   16  bus address; captured with req
//  wdata      in   8   write data; captured with req
//  is_opcode  in   1   read is an opcode fetch (SYNC); captured with req
//  busy       out  1   high from accept cycle until return to IDLE
//  ack        out  1   one-cycle completion pulse
//  rdata      out  8   last completed read data
//  ir         out  8   last completed opcode fetch
//  timeout    out  1   sticky: a transfer hit MAX_WAIT
//  ext_rdy    in   1   external memory ready (wait-state input)
//  pad_uio_in  in  8   bidirectional pin input path
//  pad_uo_out  out 8   dedicated outputs: multiplexed address
//  pad_uio_out out 8   bidirectional pin output path
//  pad_uio_oe  out 8   pin output enables (1=drive)
// BEHAVIOUR
//  - All outputs registered. States: IDLE, ADDR_HI, ADDR_LO, DATA, ACK.
//  - Reset (rst_n=0 at posedge, any state, incl. mid-transfer): state=IDLE,
//    pad_uo_out=0, pad_uio_out=0, pad_uio_oe=0, busy=0, ack=0, rdata=0,
//    ir=IR_RESET, timeout=0, wait counter=0. Aborted transfer is never acked.
//  - IDLE: pads 0/0/oe=0. req=1 -> capture rw/addr/wdata/is_opcode, busy=1,
//    next ADDR_HI. req=0 -> stay.
//  - ADDR_HI (1 cycle): pad_uo_out=addr[15:8]; pad_uio_oe=8'hFF;
//    pad_uio_out={5'b0,1'b1(hi phase),is_opcode,rw}. Next ADDR_LO.
//  - ADDR_LO (1 cycle): pad_uo_out=addr[7:0]; pad_uio_oe=8'hFF;
//    pad_uio_out={5'b0,1'b0,is_opcode,rw}. Next DATA; wait counter cleared.
//  - DATA: pad_uo_out holds addr[7:0]. Write: oe=8'hFF, uio_out=wdata.
//    Read: oe=8'h00, uio_out=0. Each cycle: ext_rdy=1 -> complete (read
//    samples pad_uio_in into rdata; if is_opcode also into ir), next ACK.
//    ext_rdy=0 -> counter+1; when counter reaches MAX_WAIT complete anyway
//    with timeout<=1, read data forced to 8'hFF (ir too if opcode).
//  - ACK (1 cycle): ack=1, pads back to 0/oe=0 (bus turnaround), next IDLE,
//    busy=0 in IDLE. req asserted during ACK is ignored; min spacing between
//    accepts is 5 cycles (zero-wait: ADDR_HI,ADDR_LO,DATA,ACK,IDLE).
//  - rdata/ir change only on completing reads; writes leave them unchanged.
//  - timeout clears only on reset. Counter is 8 bits, saturates, never wraps.
//  - Never drive oe=8'hFF in the same cycle the previous read had oe=0 without
//    the ACK/IDLE gap in between (guaranteed by state order).
// TESTING
//  1 Reset: hold rst_n=0 2 cycles -> all outputs 0, ir=8'hEA, busy=0.
//  2 Read addr=16'h12A4, opcode=1, ext_rdy=1, pad_uio_in=8'hA9 -> uo_out 8'h12
//    then 8'hA4, oe=0 in DATA, ack 4 cycles after accept, rdata=ir=8'hA9.
//  3 Write addr=16'h0200 wdata=8'h5C, ext_rdy=1 -> uio_out=8'h5C, oe=8'hFF in
//    DATA, uio_out[0]=0 in address phases; rdata/ir unchanged.
//  4 Read with ext_rdy low 3 DATA cycles -> DATA lasts 4 cycles, ack once,
//    timeout=0; req held high in ACK -> no second accept until IDLE.
//  5 Read with ext_rdy stuck 0 -> completes after MAX_WAIT=15 cycles,
//    rdata=8'hFF, timeout=1 and stays 1 over a following good transfer.
//  6 rst_n=0 during DATA of a write -> next cycle IDLE, oe=0, no ack pulse.

Source files
------------

// File: rtl/bus_interface_unit.sv
// Pad-side bus sequencer: multiplexes a 16-bit core address onto the dedicated
// outputs, then drives or samples the bidirectional pins, honouring ext_rdy wait states.
module bus_interface_unit #(
  parameter int          MAX_WAIT = 15,
  parameter logic [7:0]  IR_RESET = 8'hEA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        is_opcode,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [7:0]  ir,
  output logic        timeout,
  input  logic        ext_rdy,
  input  logic [7:0]  pad_uio_in,
  output logic [7:0]  pad_uo_out,
  output logic [7:0]  pad_uio_out,
  output logic [7:0]  pad_uio_oe
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    DATA    = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic        opcode_q, opcode_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  count_inc;

  logic        busy_d, ack_d, timeout_d;
  logic [7:0]  rdata_d, ir_d;
  logic [7:0]  uo_d, uio_d, oe_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      opcode_q    <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      count_q     <= 8'h00;
      busy        <= 1'b0;
      ack         <= 1'b0;
      rdata       <= 8'h00;
      ir          <= IR_RESET;
      timeout     <= 1'b0;
      pad_uo_out  <= 8'h00;
      pad_uio_out <= 8'h00;
      pad_uio_oe  <= 8'h00;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      busy        <= busy_d;
      ack         <= ack_d;
      rdata       <= rdata_d;
      ir          <= ir_d;
      timeout     <= timeout_d;
      pad_uo_out  <= uo_d;
      pad_uio_out <= uio_d;
      pad_uio_oe  <= oe_d;
    end
  end

  // Saturating increment so a stuck ext_rdy can never wrap the wait counter.
  assign count_inc = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    opcode_d  = opcode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    rdata_d   = rdata;
    ir_d      = ir;
    timeout_d = timeout;

    case (state_q)
      IDLE: begin
        if (req) begin
          rw_d     = rw;
          opcode_d = is_opcode;
          addr_d   = addr;
          wdata_d  = wdata;
          state_d  = ADDR_HI;
        end
      end
      ADDR_HI: state_d = ADDR_LO;
      ADDR_LO: begin
        count_d = 8'h00;
        state_d = DATA;
      end
      DATA: begin
        if (ext_rdy) begin
          if (rw_q) begin
            rdata_d = pad_uio_in;
            if (opcode_q) ir_d = pad_uio_in;
          end
          state_d = ACK;
        end else begin
          count_d = count_inc;
          if (count_inc >= MAX_WAIT_C) begin
            timeout_d = 1'b1;
            if (rw_q) begin
              rdata_d = 8'hFF;
              if (opcode_q) ir_d = 8'hFF;
            end
            state_d = ACK;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad and handshake outputs are decoded from the upcoming state so that the
  // registered pins line up exactly with the state they belong to.
  always_comb begin
    busy_d = (state_d != IDLE);
    ack_d  = 1'b0;
    uo_d   = 8'h00;
    uio_d  = 8'h00;
    oe_d   = 8'h00;

    case (state_d)
      ADDR_HI: begin
        uo_d  = addr_d[15:8];
        oe_d  = 8'hFF;
        uio_d = {5'b00000, 1'b1, opcode_d, rw_d};
      end
      ADDR_LO: begin
        uo_d  = addr_d[7:0];
        oe_d  = 8'hFF;
        uio_d = {5'b00000, 1'b0, opcode_d, rw_d};
      end
      DATA: begin
        uo_d = addr_d[7:0];
        if (!rw_d) begin
          oe_d  = 8'hFF;
          uio_d = wdata_d;
        end
      end
      ACK:     ack_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed self-checking bench for bus_interface_unit: reset, read, write,
// wait states, timeout and mid-transfer reset.
module tb_bus_interface_unit;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        is_opcode;
  logic        busy;
  logic        ack;
  logic [7:0]  rdata;
  logic [7:0]  ir;
  logic        timeout;
  logic        ext_rdy;
  logic [7:0]  pad_uio_in;
  logic [7:0]  pad_uo_out;
  logic [7:0]  pad_uio_out;
  logic [7:0]  pad_uio_oe;

  int n_assert = 0;
  int n_fail   = 0;

  bus_interface_unit #(.MAX_WAIT(15), .IR_RESET(8'hEA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .rw         (rw),
    .addr       (addr),
    .wdata      (wdata),
    .is_opcode  (is_opcode),
    .busy       (busy),
    .ack        (ack),
    .rdata      (rdata),
    .ir         (ir),
    .timeout    (timeout),
    .ext_rdy    (ext_rdy),
    .pad_uio_in (pad_uio_in),
    .pad_uo_out (pad_uo_out),
    .pad_uio_out(pad_uio_out),
    .pad_uio_oe (pad_uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before sampling.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkPads(input string tag, input logic [7:0] uo, input logic [7:0] uio, input logic [7:0] oe);
    checkOutput({tag, ".uo"},  {8'h00, pad_uo_out},  {8'h00, uo});
    checkOutput({tag, ".uio"}, {8'h00, pad_uio_out}, {8'h00, uio});
    checkOutput({tag, ".oe"},  {8'h00, pad_uio_oe},  {8'h00, oe});
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = 1'b0;
    rw         = 1'b1;
    addr       = 16'h0000;
    wdata      = 8'h00;
    is_opcode  = 1'b0;
    ext_rdy    = 1'b1;
    pad_uio_in = 8'h00;

    // Reset held for two cycles
    applyStimulus();
    applyStimulus();
    checkPads("rst", 8'h00, 8'h00, 8'h00);
    checkOutput("rst.busy", {15'd0, busy}, 16'd0);
    checkOutput("rst.ack", {15'd0, ack}, 16'd0);
    checkOutput("rst.rdata", {8'h00, rdata}, 16'h0000);
    checkOutput("rst.ir", {8'h00, ir}, 16'h00EA);
    checkOutput("rst.timeout", {15'd0, timeout}, 16'd0);
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("idle.busy", {15'd0, busy}, 16'd0);

    // Opcode read, zero wait
    $display("[TB] opcode read 12A4");
    req = 1'b1; rw = 1'b1; addr = 16'h12A4; is_opcode = 1'b1; ext_rdy = 1'b1; pad_uio_in = 8'hA9;
    applyStimulus();
    req = 1'b0;
    checkPads("rd.hi", 8'h12, 8'h07, 8'hFF);
    checkOutput("rd.hi.busy", {15'd0, busy}, 16'd1);
    applyStimulus();
    checkPads("rd.lo", 8'hA4, 8'h03, 8'hFF);
    applyStimulus();
    checkPads("rd.data", 8'hA4, 8'h00, 8'h00);
    checkOutput("rd.data.ack", {15'd0, ack}, 16'd0);
    applyStimulus();
    checkOutput("rd.ack", {15'd0, ack}, 16'd1);
    checkOutput("rd.ack.busy", {15'd0, busy}, 16'd1);
    checkPads("rd.ack", 8'h00, 8'h00, 8'h00);
    checkOutput("rd.rdata", {8'h00, rdata}, 16'h00A9);
    checkOutput("rd.ir", {8'h00, ir}, 16'h00A9);
    applyStimulus();
    checkOutput("rd.idle.ack", {15'd0, ack}, 16'd0);
    checkOutput("rd.idle.busy", {15'd0, busy}, 16'd0);

    // Write, zero wait; read registers must be untouched
    $display("[TB] write 0200");
    req = 1'b1; rw = 1'b0; addr = 16'h0200; wdata = 8'h5C; is_opcode = 1'b0; pad_uio_in = 8'h33;
    applyStimulus();
    req = 1'b0;
    checkPads("wr.hi", 8'h02, 8'h04, 8'hFF);
    applyStimulus();
    checkPads("wr.lo", 8'h00, 8'h00, 8'hFF);
    applyStimulus();
    checkPads("wr.data", 8'h00, 8'h5C, 8'hFF);
    applyStimulus();
    checkOutput("wr.ack", {15'd0, ack}, 16'd1);
    checkOutput("wr.rdata", {8'h00, rdata}, 16'h00A9);
    checkOutput("wr.ir", {8'h00, ir}, 16'h00A9);
    applyStimulus();
    checkOutput("wr.idle.busy", {15'd0, busy}, 16'd0);

    // Read with three wait cycles, req held high throughout
    $display("[TB] read 3456 with wait states");
    req = 1'b1; rw = 1'b1; addr = 16'h3456; is_opcode = 1'b0; ext_rdy = 1'b0; pad_uio_in = 8'h77;
    applyStimulus();
    checkPads("ws.hi", 8'h34, 8'h05, 8'hFF);
    applyStimulus();
    applyStimulus();
    checkPads("ws.data0", 8'h56, 8'h00, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      if (i == 3) ext_rdy = 1'b1;
      checkOutput($sformatf("ws.wait%0d.ack", i), {15'd0, ack}, 16'd0);
      checkOutput($sformatf("ws.wait%0d.oe", i), {8'h00, pad_uio_oe}, 16'h0000);
    end
    applyStimulus();
    checkOutput("ws.ack", {15'd0, ack}, 16'd1);
    checkOutput("ws.rdata", {8'h00, rdata}, 16'h0077);
    checkOutput("ws.ir", {8'h00, ir}, 16'h00A9);
    checkOutput("ws.timeout", {15'd0, timeout}, 16'd0);
    applyStimulus();
    checkOutput("ws.idle.busy", {15'd0, busy}, 16'd0);
    checkOutput("ws.idle.ack", {15'd0, ack}, 16'd0);
    applyStimulus();
    req = 1'b0;
    checkOutput("ws.reaccept.busy", {15'd0, busy}, 16'd1);
    checkPads("ws.reaccept", 8'h34, 8'h05, 8'hFF);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("ws2.ack", {15'd0, ack}, 16'd1);
    applyStimulus();

    // Timeout: ext_rdy stuck low
    $display("[TB] opcode read 8001 with ext_rdy stuck low");
    req = 1'b1; rw = 1'b1; addr = 16'h8001; is_opcode = 1'b1; ext_rdy = 1'b0; pad_uio_in = 8'h55;
    applyStimulus();
    req = 1'b0;
    applyStimulus();
    applyStimulus();
    for (int i = 1; i <= 14; i++) applyStimulus();
    checkOutput("to.wait14.ack", {15'd0, ack}, 16'd0);
    checkOutput("to.wait14.timeout", {15'd0, timeout}, 16'd0);
    applyStimulus();
    checkOutput("to.ack", {15'd0, ack}, 16'd1);
    checkOutput("to.rdata", {8'h00, rdata}, 16'h00FF);
    checkOutput("to.ir", {8'h00, ir}, 16'h00FF);
    checkOutput("to.timeout", {15'd0, timeout}, 16'd1);
    applyStimulus();

    // Good read afterwards keeps the sticky timeout
    req = 1'b1; rw = 1'b1; addr = 16'h1111; is_opcode = 1'b0; ext_rdy = 1'b1; pad_uio_in = 8'h3C;
    applyStimulus();
    req = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("good.ack", {15'd0, ack}, 16'd1);
    checkOutput("good.rdata", {8'h00, rdata}, 16'h003C);
    checkOutput("good.ir", {8'h00, ir}, 16'h00FF);
    checkOutput("good.timeout", {15'd0, timeout}, 16'd1);
    applyStimulus();

    // Reset in the DATA phase of a write
    $display("[TB] reset during write DATA");
    req = 1'b1; rw = 1'b0; addr = 16'h4000; wdata = 8'hAA; is_opcode = 1'b0; ext_rdy = 1'b0;
    applyStimulus();
    req = 1'b0;
    applyStimulus();
    applyStimulus();
    checkPads("ab.data", 8'h00, 8'hAA, 8'hFF);
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    ext_rdy = 1'b1;
    checkPads("ab.rst", 8'h00, 8'h00, 8'h00);
    checkOutput("ab.busy", {15'd0, busy}, 16'd0);
    checkOutput("ab.ack", {15'd0, ack}, 16'd0);
    checkOutput("ab.timeout", {15'd0, timeout}, 16'd0);
    checkOutput("ab.ir", {8'h00, ir}, 16'h00EA);
    checkOutput("ab.rdata", {8'h00, rdata}, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("ab.after%0d.ack", i), {15'd0, ack}, 16'd0);
      checkOutput($sformatf("ab.after%0d.busy", i), {15'd0, busy}, 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
